// File: rtl/led_chaser_multi.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// led_chaser_multi
//   Multi-pattern LED chaser with an adjustable step period. It drives LED_NUM
//   LEDs with one of four patterns (rotate left, rotate right, bounce, bar fill)
//   and advances the pattern once every `period` clock cycles. The debounced
//   speed keys halve, double or restore the period. A pause level freezes the
//   pattern. A step strobe marks every pattern advance for other board logic.
//
// Ports
//   clk          in   1        system clock, rising edge
//   reset        in   1        asynchronous, active-high reset
//   key_faster   in   1        1-cycle pulse: halve the period (floor SPEED_MIN)
//   key_slower   in   1        1-cycle pulse: double the period (cap SPEED_MAX)
//   key_restore  in   1        1-cycle pulse: period := SPEED_DEF
//   mode         in   2        0 rot-left, 1 rot-right, 2 bounce, 3 bar fill
//   pause        in   1        level: freeze pattern and step counter
//   led          out  LED_NUM  LED drive, 1 = on (registered)
//   step_tick    out  1        1-cycle pulse on every pattern advance (registered)
// -----------------------------------------------------------------------------
module led_chaser_multi #(
  parameter int LED_NUM   = 8,
  parameter int CNT_W     = 30,
  parameter int SPEED_DEF = 20,
  parameter int SPEED_MIN = 2,
  parameter int SPEED_MAX = 2**28
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_faster,
  input  logic               key_slower,
  input  logic               key_restore,
  input  logic [1:0]         mode,
  input  logic               pause,
  output logic [LED_NUM-1:0] led,
  output logic               step_tick
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  localparam logic [1:0] M_ROT_L  = 2'd0;
  localparam logic [1:0] M_ROT_R  = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;
  localparam logic [1:0] M_BAR    = 2'd3;

  // Period arithmetic is one bit wider than the register so doubling cannot wrap.
  localparam logic [CNT_W:0] DEF_W = (CNT_W+1)'(SPEED_DEF);
  localparam logic [CNT_W:0] MIN_W = (CNT_W+1)'(SPEED_MIN);
  localparam logic [CNT_W:0] MAX_W = (CNT_W+1)'(SPEED_MAX);
  localparam logic [CNT_W:0] ONE_W = (CNT_W+1)'(1);

  logic [1:0]         state_q;
  logic [CNT_W-1:0]   period_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [LED_NUM-1:0] led_q;
  logic               step_q;
  logic               dir_down_q;   // bounce direction: 0 = moving up, 1 = moving down
  logic [1:0]         mode_q;       // previous mode, for change detection

  logic               restart;
  logic               advance;
  logic [CNT_W:0]     period_w;
  logic [CNT_W:0]     half_w;
  logic [CNT_W:0]     dbl_w;
  logic [CNT_W:0]     period_nxt_w;
  logic [LED_NUM-1:0] led_init;
  logic [LED_NUM-1:0] led_adv;
  logic               dir_adv;

  assign led       = led_q;
  assign step_tick = step_q;

  // Any key or a new mode value aborts the current pattern and restarts it.
  assign restart = key_faster | key_slower | key_restore | (mode != mode_q);

  // Using >= rather than == lets a freshly shortened period take effect at once
  // even when the counter is already past the new terminal count.
  assign advance = (({1'b0, cnt_q} + ONE_W) >= {1'b0, period_q});

  // Period update: restore > faster > slower.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    period_w     = {1'b0, period_q};
    half_w       = period_w >> 1;
    dbl_w        = period_w << 1;
    period_nxt_w = period_w;
    if (key_restore) begin
      period_nxt_w = DEF_W;
    end else if (key_faster) begin
      period_nxt_w = (half_w < MIN_W) ? MIN_W : half_w;
    end else if (key_slower) begin
      period_nxt_w = (dbl_w > MAX_W) ? MAX_W : dbl_w;
    end
  end

  // Initial pattern of the active mode.
  always_comb begin
    led_init = LED_NUM'(1);
    if (mode_q == M_ROT_R) begin
      led_init = {1'b1, {(LED_NUM-1){1'b0}}};
    end
  end

  // Next pattern value on an advance.
  always_comb begin
    led_adv = led_q;
    dir_adv = dir_down_q;
    case (mode_q)
      M_ROT_L: led_adv = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
      M_ROT_R: led_adv = {led_q[0], led_q[LED_NUM-1:1]};
      M_BOUNCE: begin
        // Turn around on the end LED itself so neither end is shown twice.
        if (!dir_down_q) begin
          if (led_q[LED_NUM-1]) begin
            led_adv = led_q >> 1;
            dir_adv = 1'b1;
          end else begin
            led_adv = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            led_adv = led_q << 1;
            dir_adv = 1'b0;
          end else begin
            led_adv = led_q >> 1;
          end
        end
      end
      M_BAR: led_adv = (&led_q) ? '0 : {led_q[LED_NUM-2:0], 1'b1};
      default: led_adv = led_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      period_q   <= DEF_W[CNT_W-1:0];
      cnt_q      <= '0;
      led_q      <= '0;
      step_q     <= 1'b0;
      dir_down_q <= 1'b0;
      mode_q     <= M_ROT_L;
    end else begin
      mode_q   <= mode;
      period_q <= period_nxt_w[CNT_W-1:0];
      step_q   <= 1'b0;
      if (restart) begin
        state_q    <= S_IDLE;
        led_q      <= '0;
        cnt_q      <= '0;
        dir_down_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            led_q      <= led_init;
            cnt_q      <= '0;
            dir_down_q <= 1'b0;
            state_q    <= pause ? S_PAUSE : S_RUN;
          end
          S_RUN, S_PAUSE: begin
            // Pause is checked before the compare, so a step never fires while
            // paused; on release counting continues from the held count.
            if (pause) begin
              state_q <= S_PAUSE;
            end else begin
              state_q <= S_RUN;
              if (advance) begin
                cnt_q      <= '0;
                led_q      <= led_adv;
                dir_down_q <= dir_adv;
                step_q     <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
